// File: rtl/alu_mem_master.sv
// Bus initiator for the ALU-with-memory register block: runs write A, write B,
// write opcode, result capture and one register readback per accepted command.
module alu_mem_master #(
  parameter int RES_LAT = 2,
  parameter int RD_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [7:0]  cmd_op,
  input  logic [1:0]  cmd_rd_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_rdata,
  output logic        mem_rst,
  output logic        enable,
  output logic        rd_wr,
  output logic [1:0]  addr,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  input  logic [15:0] res_out
);

  // state    | meaning
  // IDLE     | cmd_ready high, waiting for a command
  // WR_A     | operand A write strobe issued, holding bus for two cycles
  // WR_B     | operand B write strobe issued, holding bus for two cycles
  // WR_OP    | opcode write strobe issued (launches the ALU)
  // WAIT_RES | opcode hold and result latency; captures res_out
  // RD       | readback strobe issued
  // WAIT_RD  | waiting read latency; captures rd_data
  // RESP     | response presented until rsp_ready
  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_OP, WAIT_RES, RD, WAIT_RD, RESP
  } state_t;

  // The read may only be set up once the opcode hold (2 edges) and the
  // result capture have both happened.
  localparam int         WAIT_W    = (RES_LAT > 2) ? RES_LAT : 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_W - 1);
  localparam logic [3:0] RES_TC    = 4'(WAIT_W - RES_LAT);
  localparam logic [3:0] RD_LOAD   = 4'(RD_LAT - 1);
  localparam logic [3:0] HOLD_LOAD = 4'd2;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_dec;
  logic        mem_rst_q, mem_rst_d;
  logic        enable_q, enable_d;
  logic        rd_wr_q, rd_wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  rd_addr_q, rd_addr_d;

  assign cnt_dec = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_rst_d    = 1'b0;
    enable_d     = 1'b0;
    rd_wr_d      = rd_wr_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_rdata_d  = rsp_rdata_q;
    b_d          = b_q;
    op_d         = op_q;
    rd_addr_d    = rd_addr_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          b_d         = cmd_b;
          op_d        = cmd_op;
          rd_addr_d   = cmd_rd_addr;
          cmd_ready_d = 1'b0;
          enable_d    = 1'b1;
          rd_wr_d     = 1'b0;
          addr_d      = 2'd0;
          wr_data_d   = cmd_a;
          cnt_d       = HOLD_LOAD;
          state_d     = WR_A;
        end
      end
      WR_A: begin
        if (cnt_q == 4'd0) begin
          enable_d  = 1'b1;
          addr_d    = 2'd1;
          wr_data_d = b_q;
          cnt_d     = HOLD_LOAD;
          state_d   = WR_B;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      WR_B: begin
        if (cnt_q == 4'd0) begin
          enable_d  = 1'b1;
          addr_d    = 2'd2;
          wr_data_d = op_q;
          state_d   = WR_OP;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      WR_OP: begin
        cnt_d   = WAIT_LOAD;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (cnt_q == RES_TC) rsp_result_d = res_out;
        if (cnt_q == 4'd0) begin
          enable_d = 1'b1;
          rd_wr_d  = 1'b1;
          addr_d   = rd_addr_q;
          state_d  = RD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      RD: begin
        cnt_d   = RD_LOAD;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (cnt_q == 4'd0) begin
          rsp_rdata_d = rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      mem_rst_q    <= 1'b1;
      enable_q     <= 1'b0;
      rd_wr_q      <= 1'b1;
      addr_q       <= 2'd0;
      wr_data_q    <= 8'd0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'd0;
      rsp_rdata_q  <= 8'd0;
      b_q          <= 8'd0;
      op_q         <= 8'd0;
      rd_addr_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_rst_q    <= mem_rst_d;
      enable_q     <= enable_d;
      rd_wr_q      <= rd_wr_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_rdata_q  <= rsp_rdata_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_rst    = mem_rst_q;
  assign enable     = enable_q;
  assign rd_wr      = rd_wr_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_alu_mem_master.sv
// Bench for alu_mem_master: two instances (default latencies and RES_LAT=5)
// driven against a behavioural ALU-memory model and a bus protocol monitor.
module tb_alu_mem_master;

  localparam int RL0 = 2;
  localparam int RL1 = 5;
  localparam int RDL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [7:0]  cmd_a [2];
  logic [7:0]  cmd_b [2];
  logic [7:0]  cmd_op [2];
  logic [1:0]  cmd_rd_addr [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_result [2];
  logic [7:0]  rsp_rdata [2];
  logic        mem_rst [2];
  logic        enable [2];
  logic        rd_wr [2];
  logic [1:0]  addr [2];
  logic [7:0]  wr_data [2];
  logic [7:0]  rd_data [2];
  logic [15:0] res_out [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mem_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .cmd_rd_addr(cmd_rd_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_rdata(rsp_rdata[0]), .mem_rst(mem_rst[0]), .enable(enable[0]), .rd_wr(rd_wr[0]),
    .addr(addr[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]), .res_out(res_out[0])
  );

  alu_mem_master #(.RES_LAT(RL1), .RD_LAT(RDL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .cmd_rd_addr(cmd_rd_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_rdata(rsp_rdata[1]), .mem_rst(mem_rst[1]), .enable(enable[1]), .rd_wr(rd_wr[1]),
    .addr(addr[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]), .res_out(res_out[1])
  );

  function automatic int res_lat(input int i);
    return (i == 0) ? RL0 : RL1;
  endfunction

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] op);
    case (op[1:0])
      2'd0:    return 16'(a) * 16'(b);
      2'd1:    return 16'(a) + 16'(b);
      2'd2:    return 16'(a) - 16'(b);
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [7:0] reg_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op, input logic [1:0] ra);
    case (ra)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return op;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU-memory model: registers, result valid for exactly one cycle ending at
  // the op edge + latency, read data valid for one cycle ending at read edge + RDL.
  logic [7:0]  regs [2][4];
  logic [15:0] res_val [2];
  logic [7:0]  rd_val [2];
  int          res_cd [2];
  int          rd_cd [2];
  int          acc_cyc [2];
  int          en_n [2];
  int          en_cyc [2][8];
  logic [1:0]  en_addr [2][8];
  logic        en_rw [2][8];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cmd_valid[i] === 1'b1 && cmd_ready[i] === 1'b1) begin
        acc_cyc[i] = cyc;
        en_n[i] = 0;
      end
      if (mem_rst[i] === 1'b1) begin
        for (int r = 0; r < 3; r++) regs[i][r] = 8'h00;
        regs[i][3] = 8'hA5;
        res_cd[i] = 0;
        rd_cd[i] = 0;
      end else begin
        if (res_cd[i] > 0) res_cd[i]--;
        if (rd_cd[i] > 0) rd_cd[i]--;
        if (enable[i] === 1'b1) begin
          if (en_n[i] < 8) begin
            en_cyc[i][en_n[i]] = cyc;
            en_addr[i][en_n[i]] = addr[i];
            en_rw[i][en_n[i]] = rd_wr[i];
          end
          en_n[i]++;
          if (rd_wr[i] === 1'b0) begin
            regs[i][addr[i]] = wr_data[i];
            if (addr[i] == 2'd2) begin
              res_val[i] = alu_ref(regs[i][0], regs[i][1], regs[i][2]);
              res_cd[i] = res_lat(i);
            end
          end else begin
            rd_val[i] = regs[i][addr[i]];
            rd_cd[i] = RDL;
          end
        end
      end
      res_out[i] <= (res_cd[i] == 1) ? res_val[i] : ~res_val[i];
      rd_data[i] <= (rd_cd[i] == 1) ? rd_val[i] : ~rd_val[i];
    end
  end

  // Bus protocol monitor.
  int         hold_cnt [2];
  logic [1:0] h_addr [2];
  logic [7:0] h_wd [2];
  logic       h_rd [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_rst[i] === 1'b1) chk("enable_in_reset", enable[i], 0);
      if (rst_n !== 1'b1) begin
        hold_cnt[i] = 0;
      end else begin
        if (hold_cnt[i] > 0) begin
          chk("enable_back_to_back", enable[i], 0);
          chk("addr_hold", addr[i], h_addr[i]);
          chk("rd_wr_hold", rd_wr[i], h_rd[i]);
          if (!h_rd[i]) chk("wr_data_hold", wr_data[i], h_wd[i]);
          hold_cnt[i]--;
        end
        if (enable[i] === 1'b1) begin
          chk("rd_wr_x", 32'($isunknown(rd_wr[i])), 0);
          if (rd_wr[i] === 1'b0) chk("wr_data_x", 32'($isunknown(wr_data[i])), 0);
          h_addr[i] = addr[i];
          h_wd[i] = wr_data[i];
          h_rd[i] = rd_wr[i];
          hold_cnt[i] = 2;
        end
      end
    end
  end

  task automatic start_cmd(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [1:0] ra);
    int k;
    k = 0;
    while (cmd_ready[i] !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("cmd_ready_wait", cmd_ready[i], 1);
    cmd_a[i] = a;
    cmd_b[i] = b;
    cmd_op[i] = op;
    cmd_rd_addr[i] = ra;
    cmd_valid[i] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd_a[i] = ~a;
    cmd_b[i] = ~b;
    cmd_op[i] = ~op;
    cmd_rd_addr[i] = ~ra;
  endtask

  task automatic do_cmd(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [1:0] ra, input int hold);
    int k, r, ne;
    int ee [4];
    logic [1:0] ea [4];
    logic ew [4];
    logic [15:0] er;
    logic [7:0] ed;
    er = alu_ref(a, b, op);
    ed = reg_ref(a, b, op, ra);
    r = 7 + ((res_lat(i) + 1 > 3) ? res_lat(i) + 1 : 3);
    ee = '{1, 4, 7, r};
    ea = '{2'd0, 2'd1, 2'd2, ra};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1};
    rsp_ready[i] = 1'b0;
    start_cmd(i, a, b, op, ra);
    chk("cmd_ready_after_accept", cmd_ready[i], 0);
    k = 0;
    while (rsp_valid[i] !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rsp_latency", k, r + RDL);
    chk("rsp_result", rsp_result[i], er);
    chk("rsp_rdata", rsp_rdata[i], ed);
    chk("enable_count", en_n[i], 4);
    ne = (en_n[i] < 4) ? en_n[i] : 4;
    for (int j = 0; j < ne; j++) begin
      chk("enable_edge", en_cyc[i][j] - acc_cyc[i], ee[j]);
      chk("enable_addr", en_addr[i][j], ea[j]);
      chk("enable_rd_wr", en_rw[i][j], ew[j]);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid[i], 1);
      chk("bp_result", rsp_result[i], er);
      chk("bp_rdata", rsp_rdata[i], ed);
      chk("bp_cmd_ready", cmd_ready[i], 0);
      chk("bp_enable", enable[i], 0);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid[i], 0);
    chk("cmd_ready_at_hs", cmd_ready[i], 0);
    @(posedge clk); #1;
    chk("cmd_ready_after_hs", cmd_ready[i], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      cmd_a[i] = 8'h00;
      cmd_b[i] = 8'h00;
      cmd_op[i] = 8'h00;
      cmd_rd_addr[i] = 2'd0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_rst", mem_rst[i], 1);
      chk("rst_enable", enable[i], 0);
      chk("rst_rd_wr", rd_wr[i], 1);
      chk("rst_addr", addr[i], 0);
      chk("rst_wr_data", wr_data[i], 0);
      chk("rst_cmd_ready", cmd_ready[i], 0);
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_rsp_result", rsp_result[i], 0);
      chk("rst_rsp_rdata", rsp_rdata[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_mem_rst", mem_rst[0], 0);
    chk("release_cmd_ready", cmd_ready[0], 1);

    do_cmd(0, 8'h12, 8'h34, 8'h01, 2'd0, 0);
    do_cmd(0, 8'h9C, 8'h27, 8'h00, 2'd1, 5);
    do_cmd(1, 8'h40, 8'h0F, 8'h02, 2'd2, 1);
    do_cmd(1, 8'h81, 8'h7E, 8'h03, 2'd3, 0);

    start_cmd(0, 8'hAA, 8'h55, 8'h02, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_enable", enable[0], 0);
      chk("midrst_mem_rst", mem_rst[0], 1);
      chk("midrst_rsp_valid", rsp_valid[0], 0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("post_abort_rsp_valid", rsp_valid[0], 0);
    end
    chk("post_abort_enables", en_n[0], 2);
    do_cmd(0, 8'hFF, 8'h01, 8'h01, 2'd1, 0);

    for (int n = 0; n < 100; n++) begin
      do_cmd(n % 2, 8'($urandom), 8'($urandom), 8'($urandom),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
